seq_alu_mdu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Executes RV32I base ALU ops in one cycle, and RV32M multiply/divide iteratively (radix-2, one bit per cycle) on the same request/response channel.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.
- Flags (negative, zero) are registered with the result.

---
 rtl/seq_alu_mdu.sv | 244 ++++++++++++++++++++++++
 tb/tb_seq_alu_mdu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: handshaked execute-stage ALU.
// RV32I base ops complete in one cycle. RV32M multiply/divide ops run
// iteratively, one bit per cycle, on the same request/response channel.
//
// Optional feature macro: ALU_MDU_EN
//   defined   : opcodes 16-23 (MUL..REMU) execute on the radix-2 datapath
//   undefined : the multiply/divide datapath and CALC/FIX states are not
//               built; opcodes 16-23 report illegal with latency 1
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  request handshake (in_ready only in IDLE)
//   ALUop, inputA/B     opcode and operands, latched on acceptance
//   out_valid/out_ready response handshake (result held until taken)
//   ALUResult           registered result
//   negative, zero      flags registered together with ALUResult
//   illegal             the last accepted opcode was unsupported
module seq_alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUop,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             negative,
    output logic             zero,
    output logic             illegal
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;

`ifdef ALU_MDU_EN
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd3} state_t;
`endif

    state_t state, state_next;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   imm_res;    // result of any latency-1 operation
    logic               imm_ill;
    logic [WIDTH-1:0]   result_d;
    logic               result_we;

    logic [WIDTH-1:0]   result_q;
    logic               neg_q;
    logic               zero_q;
    logic               ill_q;

    assign accept    = in_valid && in_ready;
    assign shamt     = inputB[SHAMT_W-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ALUResult = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

`ifdef ALU_MDU_EN
    // Decode of the M ops. The iterative core works on magnitudes; the
    // sign is restored in FIX.
    logic             is_m, is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic             div_zero, div_ovf, mul_zero, go_calc;
    logic [WIDTH-1:0] mag_a, mag_b, short_res;

    assign is_m     = (ALUop[4:3] == 2'b10);
    assign is_div   = ALUop[2];
    assign is_rem   = ALUop[2] & ALUop[1];
    assign a_signed = (ALUop == OP_MULH) || (ALUop == OP_MULHSU) ||
                      (ALUop == OP_DIV)  || (ALUop == OP_REM);
    assign b_signed = (ALUop == OP_MULH) || (ALUop == OP_DIV) || (ALUop == OP_REM);
    assign a_neg    = a_signed & inputA[WIDTH-1];
    assign b_neg    = b_signed & inputB[WIDTH-1];
    assign mag_a    = a_neg ? -inputA : inputA;
    assign mag_b    = b_neg ? -inputB : inputB;

    assign div_zero = is_div && (inputB == '0);
    assign div_ovf  = is_div && b_signed && (inputA == MIN_VAL) && (inputB == '1);
    assign mul_zero = !is_div && ((inputA == '0) || (inputB == '0));
    assign go_calc  = is_m && !(div_zero || div_ovf || mul_zero);

    assign short_res = div_zero ? (is_rem ? inputA : '1) :
                       div_ovf  ? (is_rem ? '0 : MIN_VAL) : '0;

    // Shared iteration registers: hi/lo hold the product (multiply) or
    // remainder/quotient (divide); mcand holds multiplicand or divisor.
    logic [SHAMT_W-1:0]   count_q;
    logic [WIDTH-1:0]     hi_q, lo_q, mcand_q;
    logic                 div_q, rem_q, low_q, res_neg_q;
    logic [WIDTH:0]       mul_sum, div_shift, div_sub;
    logic [2*WIDTH-1:0]   prod_full, prod_fix;
    logic [WIDTH-1:0]     fix_res;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, mcand_q};   // MSB set: divisor does not fit

    assign prod_full = {hi_q, lo_q};
    assign prod_fix  = res_neg_q ? -prod_full : prod_full;
    assign fix_res   = div_q ? (rem_q ? (res_neg_q ? -hi_q : hi_q)
                                      : (res_neg_q ? -lo_q : lo_q))
                             : (low_q ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);

    // NOTE: the iteration registers get an async reset like everything else;
    // they are plain flops, not a memory, so it costs nothing to keep them defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            div_q     <= 1'b0;
            rem_q     <= 1'b0;
            low_q     <= 1'b0;
            res_neg_q <= 1'b0;
        end else if (accept && go_calc) begin
            count_q   <= SHAMT_W'(WIDTH - 1);
            hi_q      <= '0;
            div_q     <= is_div;
            rem_q     <= is_rem;
            low_q     <= (ALUop == OP_MUL);
            res_neg_q <= is_rem ? a_neg : (a_neg ^ b_neg);
            lo_q      <= is_div ? mag_a : mag_b;
            mcand_q   <= is_div ? mag_b : mag_a;
        end else if (state == CALC) begin
            count_q <= count_q - SHAMT_W'(1);
            if (div_q) begin
                hi_q <= div_sub[WIDTH] ? div_shift[WIDTH-1:0] : div_sub[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], ~div_sub[WIDTH]};
            end else begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end
`endif

    // NOTE: every signal driven here gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        imm_res = '0;
        imm_ill = 1'b0;
        case (ALUop)
            OP_ADD:  imm_res = inputA + inputB;
            OP_SUB:  imm_res = inputA - inputB;
            OP_SLL:  imm_res = inputA << shamt;
            OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
            OP_XOR:  imm_res = inputA ^ inputB;
            OP_SRL:  imm_res = inputA >> shamt;
            OP_SRA:  imm_res = $signed(inputA) >>> shamt;
            OP_OR:   imm_res = inputA | inputB;
            OP_AND:  imm_res = inputA & inputB;
            default: imm_ill = 1'b1;
        endcase
`ifdef ALU_MDU_EN
        if (is_m) begin
            imm_ill = 1'b0;
            imm_res = short_res;
        end
`endif
    end

    always_comb begin
        result_we = accept;
        result_d  = imm_res;
`ifdef ALU_MDU_EN
        if (accept && go_calc) result_we = 1'b0;
        if (state == FIX) begin
            result_we = 1'b1;
            result_d  = fix_res;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) begin
                state_next = DONE;
`ifdef ALU_MDU_EN
                if (go_calc) state_next = CALC;
`endif
            end
`ifdef ALU_MDU_EN
            CALC: if (count_q == '0) state_next = FIX;
            FIX:  state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Flags are computed from the value being written so they always
    // match the registered result (and are all zero out of reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            if (accept) ill_q <= imm_ill;
            if (result_we) begin
                result_q <= result_d;
                neg_q    <= result_d[WIDTH-1];
                zero_q   <= (result_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_mdu.sv
`timescale 1ns/1ps
module tb_seq_alu_mdu;

    localparam int W = 32;
`ifdef ALU_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif
    localparam int MLAT = MDU ? W + 2 : 1;   // latency of an iterated M op

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,   OP_REMU = 5'd23;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         negative, zero, illegal;
    logic [4:0]   ALUop;
    logic [W-1:0] inputA, inputB, ALUResult;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .inputA(inputA), .inputB(inputB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .negative(negative), .zero(zero), .illegal(illegal)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, res;
        bit          ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [4:0] op, input logic [31:0] a, b, res,
                                    input bit ill, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, b,
                                  output logic [31:0] r, output bit ill, output int lat);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        p = 0; r = '0; ill = 1'b0; lat = 1;
        case (op)
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_SLL:    r = a << b[4:0];
            OP_SLT:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:   r = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    r = a ^ b;
            OP_SRL:    r = a >> b[4:0];
            OP_SRA:    r = 32'($signed(a) >>> b[4:0]);
            OP_OR:     r = a | b;
            OP_AND:    r = a & b;
            OP_MUL:    begin p = sa * sb; r = p[31:0];  end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
            OP_DIV:    if (b == 0) r = '1; else r = 32'(sa / sb);
            OP_DIVU:   if (b == 0) r = '1; else r = 32'(ua / ub);
            OP_REM:    if (b == 0) r = a;  else r = 32'(sa % sb);
            OP_REMU:   if (b == 0) r = a;  else r = 32'(ua % ub);
            default:   ill = 1'b1;
        endcase
        if (op >= 5'd16 && op <= 5'd23) begin
            if (!MDU) begin
                r = '0; ill = 1'b1;
            end else if (!((op >= 5'd20) && b == 0) &&
                         !((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) &&
                         !((op < 5'd20) && (a == 0 || b == 0))) begin
                lat = W + 2;
            end
        end
    endfunction

    // Issue one request, wait for the response and compare; leaves the
    // response pending (out_ready low) so callers can test the hold.
    task automatic exec(input string name, input logic [4:0] op, input logic [31:0] a, b,
                        input logic [31:0] exp_r, input bit exp_ill, input int exp_lat);
        int guard, lat;
        @(negedge clk);
        ALUop = op; inputA = a; inputB = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, " accept"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; ALUop = 5'($urandom); inputA = $urandom; inputB = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, ALUResult, exp_r);
        check({name, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        check({name, " negative"}, {31'd0, negative}, {31'd0, exp_r[31]});
        check({name, " zero"}, {31'd0, zero}, {31'd0, (exp_r == 0)});
    endtask

    task automatic take(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " valid drop"}, {31'd0, out_valid}, 32'd0);
        check({name, " ready again"}, {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, b;
        logic [4:0]  op;
        bit          ill;
        int          lat, sel;

        // Expected results are written from the architectural definitions.
        add_vec(OP_ADD,  32'd5,         32'd7,         32'd12,        0, 1);
        add_vec(OP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 0, 1);
        add_vec(OP_SLL,  32'd1,         32'h21,        32'd2,         0, 1);
        add_vec(OP_SRL,  32'h8000_0000, 32'h1F,        32'd1,         0, 1);
        add_vec(OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 0, 1);
        add_vec(OP_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         0, 1);
        add_vec(OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         0, 1);
        add_vec(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1);
        add_vec(OP_OR,   32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 0, 1);
        add_vec(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 1);
        add_vec(OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1);
        add_vec(5'd31,   32'd9,         32'd9,         32'd0,         1, 1);
        add_vec(OP_ADD,  32'd1,         32'd1,         32'd2,         0, 1);
        add_vec(OP_MULH,   32'h8000_0000, 32'h8000_0000, MDU ? 32'h4000_0000 : 32'd0, !MDU, MLAT);
        add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MDU ? 32'hFFFF_FFFE : 32'd0, !MDU, MLAT);
        add_vec(OP_MUL,    32'd7,         32'hFFFF_FFFD, MDU ? 32'hFFFF_FFEB : 32'd0, !MDU, MLAT);
        add_vec(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         MDU ? 32'hFFFF_FFFF : 32'd0, !MDU, MLAT);
        add_vec(OP_MUL,    32'd0,         32'd12345,     32'd0,                       !MDU, 1);
        add_vec(OP_DIV,    32'hFFFF_FFF9, 32'd2,         MDU ? 32'hFFFF_FFFD : 32'd0, !MDU, MLAT);
        add_vec(OP_REM,    32'hFFFF_FFF9, 32'd2,         MDU ? 32'hFFFF_FFFF : 32'd0, !MDU, MLAT);
        add_vec(OP_DIVU,   32'd1234,      32'd0,         MDU ? 32'hFFFF_FFFF : 32'd0, !MDU, 1);
        add_vec(OP_REMU,   32'd1234,      32'd0,         MDU ? 32'd1234      : 32'd0, !MDU, 1);
        add_vec(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, MDU ? 32'h8000_0000 : 32'd0, !MDU, 1);
        add_vec(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,                       !MDU, 1);
        add_vec(OP_DIVU,   32'hFFFF_FFFF, 32'd10,        MDU ? 32'h1999_9999 : 32'd0, !MDU, MLAT);
        add_vec(OP_REMU,   32'hFFFF_FFFF, 32'd10,        MDU ? 32'd5         : 32'd0, !MDU, MLAT);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUop = '0; inputA = '0; inputB = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", ALUResult, 32'd0);
        check("reset negative", {31'd0, negative}, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a divide, about 10 cycles into CALC.
        ALUop = OP_DIV; inputA = 32'hFFFF_FFF9; inputB = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop out_valid", {31'd0, out_valid}, 32'd0);
        check("midop result", ALUResult, 32'd0);
        check("midop illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midop in_ready", {31'd0, in_ready}, 32'd1);
        check("midop idle out_valid", {31'd0, out_valid}, 32'd0);
        exec("post_reset_add", OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        take("post_reset_add");

        // Directed vector table.
        foreach (vecs[i]) begin
            exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].res, vecs[i].ill, vecs[i].lat);
            take($sformatf("vec%0d", i));
        end

        // Result must stay stable while the consumer stalls.
        exec("hold_sub", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("hold%0d result", k), ALUResult, 32'hFFFF_FFFE);
            check($sformatf("hold%0d negative", k), {31'd0, negative}, 32'd1);
        end
        take("hold_sub");

        // Randomized operations against the reference model.
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 10)       op = 5'(sel);
            else if (sel < 18)  op = 5'(sel + 6);
            else if (sel == 18) op = 5'(10 + $urandom_range(0, 5));
            else                op = 5'(24 + $urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            model(op, a, b, r, ill, lat);
            exec($sformatf("rnd%0d op%0d", i, op), op, a, b, r, ill, lat);
            take($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
